// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage access as two 16-bit half-word transfers on an async SRAM.
// ready drops for 1+2*WAIT_CYCLES cycles per access; SRAM pins are decoded from registered state.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic [31:0]   read_data_q, read_data_d;

  logic        req;
  logic        is_hi;
  logic [16:0] word_idx;

  assign req       = rd_en | wr_en;
  assign is_hi     = (state_q == HI);
  assign word_idx  = 17'((addr_q - 32'(BASE_ADDR)) >> 2);
  assign read_data = read_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;

    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          // A simultaneous read and write request is treated as a write.
          addr_d  = address;
          data_d  = write_data;
          wr_d    = wr_en;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO, HI: begin
        sram_addr = {word_idx, is_hi};
        if (wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = is_hi ? data_q[31:16] : data_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!wr_q) begin
            if (is_hi) read_data_d[31:16] = sram_dq_in;
            else       read_data_d[15:0]  = sram_dq_in;
          end
          state_d = is_hi ? DONE : HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: pin-level SRAM, cycle-phase reference model and directed accesses.
module tb_sram_controller;
  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Pin-level asynchronous SRAM (small window of the address space).
  logic [15:0] sram_mem [64];
  initial for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_out;
  assign sram_dq_in = sram_oe_n ? 16'h0 : sram_mem[sram_addr[5:0]];

  // Reference model: word memory plus the cycle offset within the current access.
  logic [31:0] mdl [32];
  initial for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  int          phase = -1;
  logic        m_wr;
  logic [16:0] m_w;
  logic [31:0] m_data, exp_rd = 32'h0, diff;

  always @(negedge clk) begin
    logic lo, hi, act, e_ready;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    if (rst) begin
      phase  = -1;
      exp_rd = 32'h0;
    end else if (phase < 0 && (rd_en || wr_en)) begin
      phase  = 0;
      m_wr   = wr_en;
      diff   = address - BASE;
      m_w    = diff[18:2];
      m_data = write_data;
    end
    lo      = (phase >= 1) && (phase <= W);
    hi      = (phase > W) && (phase <= 2 * W);
    act     = lo || hi;
    e_ready = (phase < 0) ? !(rd_en || wr_en) : (phase == 2 * W + 1);
    e_addr  = act ? {m_w, hi} : 18'h0;
    e_dq    = (act && m_wr) ? (hi ? m_data[31:16] : m_data[15:0]) : 16'h0;
    chk("ready", 32'(ready), 32'(e_ready));
    chk("read_data", read_data, exp_rd);
    chk("sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("sram_we_n", 32'(sram_we_n), 32'(!(act && m_wr)));
    chk("sram_oe_n", 32'(sram_oe_n), 32'(!(act && !m_wr)));
    chk("sram_dq_oe", 32'(sram_dq_oe), 32'(act && m_wr));
    if (!(act && !m_wr)) chk("sram_dq_out", 32'(sram_dq_out), 32'(e_dq));
    if (!rst && phase >= 0) begin
      if (!m_wr && phase == W)         exp_rd[15:0]  = mdl[m_w[4:0]][15:0];
      if (!m_wr && phase == 2 * W)     exp_rd[31:16] = mdl[m_w[4:0]][31:16];
      if (m_wr && phase == 2 * W + 1)  mdl[m_w[4:0]] = m_data;
      phase = (phase == 2 * W + 1) ? -1 : phase + 1;
    end
  end

  // Per-cycle captures of one access; index 0 is the cycle the request first appears.
  logic [31:0] cap_rd    [40];
  logic [17:0] cap_addr  [40];
  logic [15:0] cap_dq    [40];
  logic        cap_we    [40];
  logic        cap_oe    [40];
  logic        cap_ready [40];
  int          cap_n;

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int  n;
    logic done;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      cap_rd[n] = read_data;  cap_addr[n] = sram_addr; cap_dq[n] = sram_dq_out;
      cap_we[n] = sram_we_n;  cap_oe[n] = sram_oe_n;   cap_ready[n] = ready;
      if (n > 0 && ready) done = 1'b1;
      else n++;
    end
    cap_n = n;
    chk("access_completes", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    chk("wr_done_cycle", 32'(cap_n), 32'd5);
    chk("wr_ready_c0", 32'(cap_ready[0]), 32'd0);
    chk("wr_ready_c4", 32'(cap_ready[4]), 32'd0);
    chk("wr_addr_c1", 32'(cap_addr[1]), 32'd2);
    chk("wr_dq_c1", 32'(cap_dq[1]), 32'h0000BEEF);
    chk("wr_we_c2", 32'(cap_we[2]), 32'd0);
    chk("wr_addr_c3", 32'(cap_addr[3]), 32'd3);
    chk("wr_dq_c4", 32'(cap_dq[4]), 32'h0000DEAD);
    chk("wr_we_c5", 32'(cap_we[5]), 32'd1);

    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("rd_data_c5", cap_rd[5], 32'hDEADBEEF);
    chk("rd_oe_c0", 32'(cap_oe[0]), 32'd1);
    chk("rd_oe_c1", 32'(cap_oe[1]), 32'd0);
    chk("rd_oe_c4", 32'(cap_oe[4]), 32'd0);
    chk("rd_oe_c5", 32'(cap_oe[5]), 32'd1);

    access(1'b0, 1'b1, 32'd1024, 32'h11112222);
    access(1'b0, 1'b1, 32'd1032, 32'h33334444);
    chk("b2b_idle_ready", 32'(cap_ready[0]), 32'd0);
    chk("b2b_lo_addr", 32'(cap_addr[1]), 32'd4);
    chk("b2b_done_cycle", 32'(cap_n), 32'd5);
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("b2b_read", cap_rd[5], 32'h33334444);

    access(1'b1, 1'b1, 32'd1024, 32'h55556666);
    chk("both_is_write_we", 32'(cap_we[1]), 32'd0);
    chk("both_rd_unchanged", cap_rd[5], 32'h33334444);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("both_readback", cap_rd[5], 32'h55556666);

    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_we_before_rst", 32'(sram_we_n), 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_read_data", read_data, 32'h0);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences 32-bit data-memory accesses of the ARM pipeline's MEM stage onto a 16-bit asynchronous external SRAM. It takes the byte address computed by the execute-stage ALU and the store value from the register file. It performs each access as two 16-bit half-word transfers and holds `ready` low so the pipeline freezes until the access completes.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: cycles each half-word transfer is held on the SRAM pins; must be at least 1.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request from the MEM stage.
- `rd_en` in 1: load request from the MEM stage.
- `address` in 32: byte address, equal to the ALU result.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: high when no access is pending; low freezes the pipeline.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data driven to the SRAM data bus.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out`; the top level builds the inout.
- `sram_dq_in` in 16: data read back from the SRAM bus.
- `sram_we_n` out 1: active-low SRAM write enable.
- `sram_oe_n` out 1: active-low SRAM output enable.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, truncated to 17 bits. Address bits [1:0] are ignored; accesses are word-aligned only.
- Low half-word is at `{w,1'b0}` and carries `data[15:0]`. High half-word is at `{w,1'b1}` and carries `data[31:16]`.
- FSM states: IDLE, LO, HI, DONE. A counter `cnt` runs from 0 to WAIT_CYCLES-1.
- IDLE, no request: stay in IDLE; `ready`=1.
- IDLE, `rd_en` or `wr_en` high:
  - `ready`=0 in that same cycle (combinational).
  - Latch `address`, `write_data` and the operation type; clear `cnt`; go to LO.
  - If `rd_en` and `wr_en` are both high, the access is a write.
- LO:
  - Drive the low address.
  - Write: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out`=`data[15:0]`.
  - Read: `sram_oe_n`=0, `sram_dq_oe`=0.
  - `cnt` increments each cycle. In the cycle where `cnt`==WAIT_CYCLES-1: for a read, capture `sram_dq_in` into `read_data[15:0]`; clear `cnt`; go to HI.
- HI: same as LO, but with the high address and `data[31:16]`. Capture goes to `read_data[31:16]`. Exit goes to DONE.
- DONE: `ready`=1 for exactly one cycle; the pipeline advances on this edge. Go to IDLE unconditionally.
- A request present in the following IDLE cycle is a new instruction and starts a new access.
- Upstream contract: while `ready`=0, `rd_en`, `wr_en`, `address` and `write_data` are held stable by the freeze. The controller uses its latched copies in any case.
- `read_data` changes only on read captures. Writes leave it unchanged.
- Outside LO and HI: `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0, `sram_addr`=0.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, latched address and data 0.
  - `read_data`=0, `ready`=1 (with no request present).
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- Latency: request first seen in IDLE at cycle 0 gives `ready`=1 in cycle 1+2·WAIT_CYCLES. `ready` is low for 1+2·WAIT_CYCLES cycles in total. With the defaults: LO in cycles 1–2, HI in 3–4, DONE in 5.
- `read_data` is fully valid from the DONE cycle until the next read capture.
- SRAM control outputs are registered or decoded from state, so they are glitch-free per cycle. `sram_we_n` is low for exactly WAIT_CYCLES cycles per half.
- Back-to-back accesses: DONE is followed by IDLE. A second request therefore sees `ready`=0 again in the IDLE cycle and starts LO one cycle later. Minimum spacing is 2+2·WAIT_CYCLES cycles.
- Reset asserted mid-access: immediate return to IDLE with all outputs at reset values. A partial write may remain in the SRAM; `read_data` is 0.
- WAIT_CYCLES=1: LO and HI each last one cycle, and capture happens in that cycle.

## Test plan
- Reset with no request: `ready`=1, `read_data`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, all addresses 0.
- Write `address`=1028, `write_data`=0xDEADBEEF, WAIT_CYCLES=2:
  - `ready` low in cycles 0–4, high in cycle 5.
  - Cycles 1–2: `sram_addr`=2, `sram_dq_out`=0xBEEF, `sram_we_n`=0.
  - Cycles 3–4: `sram_addr`=3, `sram_dq_out`=0xDEAD.
- Read back from 1028 with an SRAM model: `read_data`=0xDEADBEEF in cycle 5; `sram_oe_n`=0 only in cycles 1–4; `sram_dq_oe`=0 throughout.
- Two back-to-back writes (1024, then 1032) followed by a read of 1032: the second access starts the cycle after DONE, and the read returns the second value.
- `rd_en` and `wr_en` both high: the access is a write and `read_data` is unchanged.
- `rst` pulsed in cycle 3 of a write: state is IDLE and `sram_we_n`=1 immediately, before the next edge; `ready`=1 after reset when no request is present.
